// File: rtl/stream_demux_1_n_pkg.sv
// Shared definitions for the stream_demux_1_n slice: FSM state encodings and counter width.
package stream_demux_1_n_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/demux_sel_dec.sv
// Select decoder: binary channel select to one-hot, plus a flag for selects with no channel.
module demux_sel_dec #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [N_CH-1:0]  onehot_o,
    output logic             out_of_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            onehot_o[k] = (sel_i == SEL_W'(k));
        end
        // No bit matches exactly when the select names a channel that does not exist.
        out_of_range_o = ~|onehot_o;
    end

endmodule

// File: rtl/stream_demux_1_n.sv
// Registered 1-to-N valid/ready stream demux with a one-entry holding register.
// Optional per-channel transfer counters are enabled by defining DEMUX_COUNT_EN.
module stream_demux_1_n
    import stream_demux_1_n_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sel_err
`ifdef DEMUX_COUNT_EN
    ,
    output logic [N_CH*COUNT_W-1:0] ch_count
`endif
);

    logic              state_q, state_d;
    logic [N_CH-1:0]   oh_q, oh_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [N_CH-1:0]   in_oh;
    logic              in_oor;
    logic              out_fire;
    logic              in_fire;

    demux_sel_dec #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel_i          (in_sel),
        .onehot_o       (in_oh),
        .out_of_range_o (in_oor)
    );

    // The destination is held already decoded, so out_valid can never be multi-hot.
    assign out_valid = oh_q;
    assign out_data  = data_q;
    assign sel_err   = err_q;

    assign out_fire = |(oh_q & out_ready);
    assign in_ready = en & ((state_q == ST_EMPTY) | out_fire);
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        oh_d    = oh_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (out_fire) begin
            state_d = ST_EMPTY;
            oh_d    = '0;
        end
        if (in_fire) begin
            if (in_oor) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_FULL;
                oh_d    = in_oh;
                data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            oh_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            oh_q    <= oh_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [N_CH-1:0][COUNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (oh_q[k] && out_ready[k]) begin
                    cnt_q[k] <= cnt_q[k] + COUNT_W'(1);
                end
            end
        end
    end

    assign ch_count = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Testbench for stream_demux_1_n (5 channels, so out-of-range selects exist); queue-based model.
module tb_stream_demux_1_n;

    localparam int unsigned N_CH   = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_data;
    logic [N_CH-1:0]   out_valid;
    logic [N_CH-1:0]   out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sel_err;
`ifdef DEMUX_COUNT_EN
    logic [N_CH*16-1:0] ch_count;
`endif

    always #5 clk = ~clk;

    stream_demux_1_n #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
`ifdef DEMUX_COUNT_EN
        ,
        .ch_count  (ch_count)
`endif
    );

    typedef struct {
        int unsigned       ch;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t       held[$];
    bit          exp_err;
    int unsigned fires[N_CH];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return en && (held.size() == 0 || out_ready[held[0].ch]);
    endfunction

    task automatic compare_outputs();
        logic [N_CH-1:0] ov;
        ov = '0;
        if (held.size() != 0) ov[held[0].ch] = 1'b1;
        check_eq("out_valid", 32'(out_valid), 32'(ov));
        if (held.size() != 0) check_eq("out_data", 32'(out_data), 32'(held[0].data));
        check_eq("in_ready", 32'(in_ready), 32'(model_ready()));
        check_eq("sel_err", 32'(sel_err), 32'(exp_err));
`ifdef DEMUX_COUNT_EN
        for (int k = 0; k < int'(N_CH); k++)
            check_eq("ch_count", 32'(ch_count[k*16 +: 16]), fires[k]);
`endif
    endtask

    // Advance the reference by one clock edge using the inputs presented for that edge.
    task automatic model_update();
        bit rdy, ofire, ifire;
        rdy   = model_ready();
        ofire = held.size() != 0 && out_ready[held[0].ch];
        ifire = in_valid && rdy;
        if (ofire) begin
            fires[held[0].ch] = (fires[held[0].ch] + 1) % 65536;
            void'(held.pop_front());
        end
        exp_err = ifire && (int'(in_sel) >= int'(N_CH));
        if (ifire && int'(in_sel) < int'(N_CH))
            held.push_back('{int'(in_sel), in_data});
    endtask

    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d,
                        input logic [N_CH-1:0] ordy, input logic e);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        en        = e;
        #1;
        compare_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        held.delete();
        exp_err = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) fires[k] = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        @(negedge clk);
        do_reset(2);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_sel_err", 32'(sel_err), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);

        // Single transfer to channel 2.
        step(1'b1, 3'd2, 8'hA5, 5'b00100, 1'b1);
        check_eq("t2_valid", 32'(out_valid), 32'h04);
        check_eq("t2_data", 32'(out_data), 32'hA5);
        step(1'b0, 3'd0, 8'h00, 5'b00100, 1'b1);
        check_eq("t2_drained", 32'(out_valid), 32'h00);

        // Back-to-back stream across channels 0..3.
        for (int s = 0; s < 4; s++) step(1'b1, SEL_W'(s), 8'(8'h10 + s), 5'b11111, 1'b1);
        step(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);

        // Backpressure on channel 1; producer keeps offering words that must be ignored.
        step(1'b1, 3'd1, 8'h3C, 5'b00000, 1'b1);
        repeat (5) begin
            check_eq("bp_valid", 32'(out_valid), 32'h02);
            check_eq("bp_data", 32'(out_data), 32'h3C);
            step(1'b1, SEL_W'($urandom_range(0, 4)), 8'($urandom), 5'b00000, 1'b1);
        end
        step(1'b0, 3'd0, 8'h00, 5'b00010, 1'b1);

        // Out-of-range select is dropped with a one-cycle error pulse.
        step(1'b1, 3'd6, 8'hEE, 5'b00000, 1'b1);
        check_eq("oor_err", 32'(sel_err), 32'd1);
        check_eq("oor_valid", 32'(out_valid), 32'd0);
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b1);
        check_eq("oor_err_clr", 32'(sel_err), 32'd0);

        // Enable low while full still drains; reset while full discards the word.
        step(1'b1, 3'd2, 8'h77, 5'b00000, 1'b1);
        step(1'b1, 3'd3, 8'h11, 5'b00000, 1'b0);
        step(1'b1, 3'd3, 8'h11, 5'b00100, 1'b0);
        check_eq("en0_drained", 32'(out_valid), 32'd0);
        step(1'b1, 3'd4, 8'h42, 5'b00000, 1'b1);
        do_reset(1);
        #1;
        check_eq("rst_full_valid", 32'(out_valid), 32'd0);

        repeat (3) step(1'b1, 3'd2, 8'h5A, 5'b00100, 1'b1);
        step(1'b0, 3'd0, 8'h00, 5'b00100, 1'b1);
`ifdef DEMUX_COUNT_EN
        check_eq("cnt_ch2", 32'(ch_count[47:32]), 32'd3);
`endif

        // Randomized traffic, including out-of-range selects and enable toggling.
        repeat (400) begin
            step(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)), 8'($urandom),
                 N_CH'($urandom), 1'($urandom_range(0, 7) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
